// File: rtl/usr_burst_shifter_if.sv
// Handshake/data bundle for usr_burst_shifter: control and data in, register state and status out.
interface usr_burst_shifter_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sr_in;
   logic             sl_in;
   logic             burst_start;
   logic [CNT_W-1:0] burst_len;
   logic [WIDTH-1:0] q;
   logic             shout;
   logic             busy;
   logic             done;

   modport master (
      output mode, d, sr_in, sl_in, burst_start, burst_len,
      input  q, shout, busy, done
   );

   modport slave (
      input  mode, d, sr_in, sl_in, burst_start, burst_len,
      output q, shout, busy, done
   );
endinterface

// File: rtl/usr_burst_shifter.sv
// Universal shift register (hold/load/shift/rotate/ashr) with an autonomous burst engine
// that repeats one shift or rotate a latched number of times and pulses done at the end.
module usr_burst_shifter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input logic              clk,
   input logic              reset,
   usr_burst_shifter_if.slave bus
);

   localparam logic [2:0] ModeHold = 3'b000;
   localparam logic [2:0] ModeShr  = 3'b001;
   localparam logic [2:0] ModeShl  = 3'b010;
   localparam logic [2:0] ModeLoad = 3'b011;
   localparam logic [2:0] ModeRotr = 3'b100;
   localparam logic [2:0] ModeRotl = 3'b101;
   localparam logic [2:0] ModeAshr = 3'b110;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bmode_q, bmode_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             shout_q, shout_d;
   logic             done_q, done_d;
   logic [2:0]       op;

   function automatic logic is_burst_mode(input logic [2:0] m);
      return (m == ModeShr) || (m == ModeShl) || (m == ModeRotr) ||
             (m == ModeRotl) || (m == ModeAshr);
   endfunction

   // Control: pick which op (if any) is applied this edge and sequence the burst.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bmode_d = bmode_q;
      done_d  = 1'b0;
      op      = ModeHold;
      unique case (state_q)
         StIdle: begin
            if (bus.burst_start && is_burst_mode(bus.mode)) begin
               bmode_d = bus.mode;
               if (bus.burst_len != '0) begin
                  state_d = StBurst;
                  cnt_d   = bus.burst_len;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               op = bus.mode;
            end
         end
         StBurst: begin
            op    = bmode_q;
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath: one-bit move per step; shout keeps its value for hold/load/reserved.
   always_comb begin
      q_d     = q_q;
      shout_d = shout_q;
      unique case (op)
         ModeShr: begin
            q_d     = {bus.sr_in, q_q[WIDTH-1:1]};
            shout_d = q_q[0];
         end
         ModeShl: begin
            q_d     = {q_q[WIDTH-2:0], bus.sl_in};
            shout_d = q_q[WIDTH-1];
         end
         ModeLoad: q_d = bus.d;
         ModeRotr: begin
            q_d     = {q_q[0], q_q[WIDTH-1:1]};
            shout_d = q_q[0];
         end
         ModeRotl: begin
            q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            shout_d = q_q[WIDTH-1];
         end
         ModeAshr: begin
            q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            shout_d = q_q[0];
         end
         default: begin
            q_d     = q_q;
            shout_d = shout_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bmode_q <= ModeHold;
         q_q     <= '0;
         shout_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bmode_q <= bmode_d;
         q_q     <= q_d;
         shout_q <= shout_d;
         done_q  <= done_d;
      end
   end

   assign bus.q     = q_q;
   assign bus.shout = shout_q;
   assign bus.busy  = (state_q == StBurst);
   assign bus.done  = done_q;

endmodule

// File: tb/tb_usr_burst_shifter.sv
// Bench for usr_burst_shifter: arithmetic reference model checked every cycle, directed
// literal cases, then randomized mode/burst/reset traffic.
module tb_usr_burst_shifter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;

   // Reference state: integers, busy derived from steps still owed.
   int mq, mshout, mdone, left, bmode;

   usr_burst_shifter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   usr_burst_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic apply_op(input int m);
      case (m)
         1: begin mshout = mq % 2;   mq = mq / 2 + (bus.sr_in ? 128 : 0); end
         2: begin mshout = mq / 128; mq = (mq * 2 + int'(bus.sl_in)) % 256; end
         3: mq = int'(bus.d);
         4: begin mshout = mq % 2;   mq = mq / 2 + (mq % 2) * 128; end
         5: begin mshout = mq / 128; mq = (mq * 2) % 256 + mq / 128; end
         6: begin mshout = mq % 2;   mq = mq / 2 + (mq >= 128 ? 128 : 0); end
         default: ;
      endcase
   endtask

   task automatic model_edge();
      int m;
      m = int'(bus.mode);
      if (!rst_n) begin
         mq = 0; mshout = 0; mdone = 0; left = 0;
      end else begin
         mdone = 0;
         if (left > 0) begin
            apply_op(bmode);
            left--;
            if (left == 0) mdone = 1;
         end else if (bus.burst_start && (m == 1 || m == 2 || m == 4 || m == 5 || m == 6)) begin
            bmode = m;
            left  = int'(bus.burst_len);
            if (left == 0) mdone = 1;
         end else begin
            apply_op(m);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_in(input logic [2:0] m, input logic [7:0] dd, input logic sr,
                         input logic sl, input logic st, input logic [CNT_W-1:0] len);
      bus.mode = m; bus.d = dd; bus.sr_in = sr; bus.sl_in = sl;
      bus.burst_start = st; bus.burst_len = len;
   endtask

   task automatic lit(input string name, input logic [7:0] eq, input logic es,
                      input logic eb, input logic ed);
      check({name, "_q"}, 32'(bus.q), 32'(eq));
      check({name, "_shout"}, 32'(bus.shout), 32'(es));
      check({name, "_busy"}, 32'(bus.busy), 32'(eb));
      check({name, "_done"}, 32'(bus.done), 32'(ed));
      check({name, "_model_q"}, 32'(mq), 32'(eq));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_q", 32'(bus.q), 32'(mq));
         check("cyc_shout", 32'(bus.shout), 32'(mshout));
         check("cyc_busy", 32'(bus.busy), 32'(left > 0));
         check("cyc_done", 32'(bus.done), 32'(mdone));
      end
   end

   initial begin
      mq = 0; mshout = 0; mdone = 0; left = 0; bmode = 0;
      rst_n = 1'b0;
      set_in(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      tick();
      chk_en = 1'b1;
      rst_n  = 1'b1;

      // Reset clears a loaded value
      set_in(3'b011, 8'h5A, 1'b0, 1'b0, 1'b0, '0);
      tick();
      rst_n = 1'b0;
      tick();
      lit("rst", 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      set_in(3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, '0); tick();
      set_in(3'b001, 8'h00, 1'b1, 1'b0, 1'b0, '0); tick();
      lit("shr", 8'hD2, 1'b1, 1'b0, 1'b0);

      set_in(3'b011, 8'h81, 1'b0, 1'b0, 1'b0, '0); tick();
      set_in(3'b101, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick();
      lit("rotl", 8'h03, 1'b1, 1'b0, 1'b0);
      set_in(3'b011, 8'h01, 1'b0, 1'b0, 1'b0, '0); tick();
      set_in(3'b100, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick();
      lit("rotr", 8'h80, 1'b1, 1'b0, 1'b0);

      set_in(3'b011, 8'h90, 1'b0, 1'b0, 1'b0, '0); tick();
      set_in(3'b110, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick();
      lit("ashr", 8'hC8, 1'b0, 1'b0, 1'b0);
      set_in(3'b011, 8'h90, 1'b0, 1'b0, 1'b0, '0); tick();
      set_in(3'b010, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick();
      lit("shl", 8'h20, 1'b1, 1'b0, 1'b0);

      // Burst of three left shifts; inputs scrambled while busy
      set_in(3'b011, 8'h0F, 1'b0, 1'b0, 1'b0, '0); tick();
      set_in(3'b010, 8'h00, 1'b0, 1'b1, 1'b1, CNT_W'(3)); tick();
      lit("b_start", 8'h0F, 1'b1, 1'b1, 1'b0);
      set_in(3'b011, 8'hEE, 1'b0, 1'b1, 1'b1, CNT_W'(7)); tick();
      lit("b_s1", 8'h1F, 1'b0, 1'b1, 1'b0);
      set_in(3'b000, 8'h33, 1'b0, 1'b1, 1'b0, CNT_W'(1)); tick();
      lit("b_s2", 8'h3F, 1'b0, 1'b1, 1'b0);
      set_in(3'b101, 8'h44, 1'b0, 1'b1, 1'b0, '0); tick();
      lit("b_s3", 8'h7F, 1'b0, 1'b0, 1'b1);
      set_in(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick();
      lit("b_after", 8'h7F, 1'b0, 1'b0, 1'b0);

      // Reset aborts a burst mid-way, then a zero-length burst
      set_in(3'b011, 8'h0F, 1'b0, 1'b0, 1'b0, '0); tick();
      set_in(3'b010, 8'h00, 1'b0, 1'b0, 1'b1, CNT_W'(5)); tick();
      set_in(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick();
      rst_n = 1'b0; tick();
      lit("abort", 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1; tick();
      lit("abort_nodone", 8'h00, 1'b0, 1'b0, 1'b0);
      set_in(3'b011, 8'h3C, 1'b0, 1'b0, 1'b0, '0); tick();
      set_in(3'b001, 8'h00, 1'b1, 1'b0, 1'b1, '0); tick();
      lit("len0", 8'h3C, 1'b0, 1'b0, 1'b1);
      set_in(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, '0); tick();
      lit("len0_after", 8'h3C, 1'b0, 1'b0, 1'b0);

      // Non-burst mode with start set just executes (load)
      set_in(3'b011, 8'h96, 1'b0, 1'b0, 1'b1, CNT_W'(4)); tick();
      lit("start_load", 8'h96, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 4000; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         set_in(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), CNT_W'($urandom_range(0, WIDTH)));
         tick();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
